// File: rtl/matrix_multiplier.sv
// ============================================================================
// Module   : matrix_multiplier
// Brief    : 2x2 complex fixed-point matrix product on one time-shared complex
//            MAC. Optional build macro: MATRIX_MULTIPLIER_ROUND_EN (round half up).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_multiplier #(
   parameter int NUMERIC_BITS = 18,
   parameter int FRAC_BITS    = 16
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic [1:0][1:0][1:0][NUMERIC_BITS-1:0]     mtx_a,
   input  logic [1:0][1:0][1:0][NUMERIC_BITS-1:0]     mtx_b,
   input  logic                                       ready,
   output logic                                       busy,
   output logic                                       done,
   output logic [1:0][1:0][1:0][NUMERIC_BITS-1:0]     result,
   output logic                                       overflow
);

   localparam int P_W   = 2 * NUMERIC_BITS;
   localparam int ACC_W = P_W + 2;

   localparam logic signed [ACC_W-1:0] c_SAT_MAX =
      {{(ACC_W-NUMERIC_BITS+1){1'b0}}, {(NUMERIC_BITS-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] c_SAT_MIN =
      {{(ACC_W-NUMERIC_BITS+1){1'b1}}, {(NUMERIC_BITS-1){1'b0}}};
`ifdef MATRIX_MULTIPLIER_ROUND_EN
   localparam logic signed [ACC_W-1:0] c_RND =
      {{(ACC_W-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
`endif

   typedef logic [1:0][1:0][1:0][NUMERIC_BITS-1:0] mtx_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [2:0]               cnt_q, cnt_d;
   mtx_t                     a_q, a_d, b_q, b_d;
   mtx_t                     stage_q, stage_d;
   mtx_t                     result_q, result_d;
   logic signed [ACC_W-1:0]  acc_re_q, acc_re_d, acc_im_q, acc_im_d;
   logic                     sticky_q, sticky_d;
   logic                     ovf_q, ovf_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;

   function automatic logic signed [P_W-1:0] sx(input logic [NUMERIC_BITS-1:0] v);
      sx = $signed({{NUMERIC_BITS{v[NUMERIC_BITS-1]}}, v});
   endfunction

   function automatic logic signed [ACC_W-1:0] px(input logic signed [P_W-1:0] v);
      px = $signed({{2{v[P_W-1]}}, v});
   endfunction

   // Returns {clamped, value}: floor (or round-half-up) shift, then saturate.
   function automatic logic [NUMERIC_BITS:0] fin(input logic signed [ACC_W-1:0] v);
      logic signed [ACC_W-1:0] s;
`ifdef MATRIX_MULTIPLIER_ROUND_EN
      s = (v + c_RND) >>> FRAC_BITS;
`else
      s = v >>> FRAC_BITS;
`endif
      if (s > c_SAT_MAX)
         fin = {1'b1, c_SAT_MAX[NUMERIC_BITS-1:0]};
      else if (s < c_SAT_MIN)
         fin = {1'b1, c_SAT_MIN[NUMERIC_BITS-1:0]};
      else
         fin = {1'b0, s[NUMERIC_BITS-1:0]};
   endfunction

   // Step counter decodes to element (i,j) and inner index k.
   logic                     w_i, w_j, w_k;
   logic signed [P_W-1:0]    w_ar, w_ai, w_br, w_bi;
   logic signed [P_W-1:0]    w_rr, w_ii, w_ri, w_ir;
   logic signed [ACC_W-1:0]  w_p_re, w_p_im, w_sum_re, w_sum_im;
   logic [NUMERIC_BITS:0]    w_fin_re, w_fin_im;

   assign w_i      = cnt_q[2];
   assign w_j      = cnt_q[1];
   assign w_k      = cnt_q[0];
   assign w_ar     = sx(a_q[w_i][w_k][0]);
   assign w_ai     = sx(a_q[w_i][w_k][1]);
   assign w_br     = sx(b_q[w_k][w_j][0]);
   assign w_bi     = sx(b_q[w_k][w_j][1]);
   assign w_rr     = w_ar * w_br;
   assign w_ii     = w_ai * w_bi;
   assign w_ri     = w_ar * w_bi;
   assign w_ir     = w_ai * w_br;
   assign w_p_re   = px(w_rr) - px(w_ii);
   assign w_p_im   = px(w_ri) + px(w_ir);
   assign w_sum_re = acc_re_q + w_p_re;
   assign w_sum_im = acc_im_q + w_p_im;
   assign w_fin_re = fin(w_sum_re);
   assign w_fin_im = fin(w_sum_im);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      stage_d  = stage_q;
      result_d = result_q;
      acc_re_d = acc_re_q;
      acc_im_d = acc_im_q;
      sticky_d = sticky_q;
      ovf_d    = ovf_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ready) begin
               a_d      = mtx_a;
               b_d      = mtx_b;
               sticky_d = 1'b0;
               busy_d   = 1'b1;
               cnt_d    = 3'd0;
               state_d  = S_MAC;
            end
         end
         S_MAC: begin
            cnt_d = cnt_q + 3'd1;
            if (!w_k) begin
               acc_re_d = w_p_re;
               acc_im_d = w_p_im;
            end else begin
               stage_d[w_i][w_j][0] = w_fin_re[NUMERIC_BITS-1:0];
               stage_d[w_i][w_j][1] = w_fin_im[NUMERIC_BITS-1:0];
               sticky_d = sticky_q | w_fin_re[NUMERIC_BITS] | w_fin_im[NUMERIC_BITS];
            end
            // Last element is forwarded so result lands complete at once.
            if (cnt_q == 3'd7) begin
               result_d = stage_d;
               ovf_d    = sticky_d;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 3'd0;
         a_q      <= '0;
         b_q      <= '0;
         stage_q  <= '0;
         result_q <= '0;
         acc_re_q <= '0;
         acc_im_q <= '0;
         sticky_q <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         stage_q  <= stage_d;
         result_q <= result_d;
         acc_re_q <= acc_re_d;
         acc_im_q <= acc_im_d;
         sticky_q <= sticky_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_multiplier.sv
// ============================================================================
// Module   : tb_matrix_multiplier
// Brief    : Directed and random checks of matrix_multiplier against a plain
//            integer complex-matrix model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_multiplier;

   localparam int N = 18;
   localparam int F = 16;

   typedef logic [1:0][1:0][1:0][N-1:0] mat_t;

   logic clk, reset, ready, busy, done, overflow;
   mat_t mtx_a, mtx_b, result;

   int total = 0;
   int bad   = 0;

   matrix_multiplier #(.NUMERIC_BITS(N), .FRAC_BITS(F)) dut (
      .clk(clk), .reset(reset), .mtx_a(mtx_a), .mtx_b(mtx_b), .ready(ready),
      .busy(busy), .done(done), .result(result), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic mat_t mk(input int r00, i00, r01, i01, r10, i10, r11, i11);
      mat_t m;
      m[0][0][0] = N'(r00); m[0][0][1] = N'(i00);
      m[0][1][0] = N'(r01); m[0][1][1] = N'(i01);
      m[1][0][0] = N'(r10); m[1][0][1] = N'(i10);
      m[1][1][0] = N'(r11); m[1][1][1] = N'(i11);
      return m;
   endfunction

   function automatic longint sv(input logic [N-1:0] v);
      return longint'($signed(v));
   endfunction

   function automatic longint scale(input longint acc, inout logic ovf);
      longint s;
`ifdef MATRIX_MULTIPLIER_ROUND_EN
      acc = acc + (64'sd1 <<< (F-1));
`endif
      s = acc >>> F;
      if (s > 131071)       begin s = 131071;  ovf = 1'b1; end
      else if (s < -131072) begin s = -131072; ovf = 1'b1; end
      return s;
   endfunction

   task automatic model(input mat_t A, input mat_t B, output mat_t R, output logic ovf);
      longint re, im;
      ovf = 1'b0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            re = 0; im = 0;
            for (int k = 0; k < 2; k++) begin
               re += sv(A[i][k][0]) * sv(B[k][j][0]) - sv(A[i][k][1]) * sv(B[k][j][1]);
               im += sv(A[i][k][0]) * sv(B[k][j][1]) + sv(A[i][k][1]) * sv(B[k][j][0]);
            end
            R[i][j][0] = N'(scale(re, ovf));
            R[i][j][1] = N'(scale(im, ovf));
         end
   endtask

   // One operation: start, scramble inputs after the start edge, check timing and values.
   task automatic run(input string tag, input mat_t A, input mat_t B);
      mat_t er;
      logic eo;
      int lat, bcnt;
      model(A, B, er, eo);
      @(negedge clk);
      mtx_a = A; mtx_b = B; ready = 1'b1;
      @(posedge clk);
      #1;
      ready = 1'b0;
      mtx_a = {$urandom, $urandom, $urandom, $urandom, $urandom};
      mtx_b = {$urandom, $urandom, $urandom, $urandom, $urandom};
      bcnt = busy ? 1 : 0;
      lat = 21;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (done) begin lat = n; break; end
         if (busy) bcnt++;
      end
      check({tag, ".latency"}, 144'(lat), 144'(8));
      check({tag, ".busy_cycles"}, 144'(bcnt), 144'(8));
      check({tag, ".busy_at_done"}, 144'(busy), 144'(0));
      check({tag, ".result"}, result, er);
      check({tag, ".overflow"}, 144'(overflow), 144'(eo));
      @(posedge clk);
      #1;
      check({tag, ".done_pulse"}, 144'(done), 144'(0));
   endtask

   mat_t ident, hm, cx, sat, bm, tmp;
   logic [19:0] bz, dn, ebz, edn;
   int dcnt;

   initial begin
      reset = 1'b1; ready = 1'b0; mtx_a = '0; mtx_b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset.busy", 144'(busy), 144'(0));
      check("reset.done", 144'(done), 144'(0));
      check("reset.overflow", 144'(overflow), 144'(0));
      check("reset.result", result, 144'(0));
      @(negedge clk);
      reset = 1'b0;

      ident = mk(65536, 0, 0, 0, 0, 0, 65536, 0);
      bm    = mk(1, -2, 3, -4, -5, 6, -7, 8);
      run("identity", ident, bm);
      check("identity.equals_b", result, bm);

      hm = mk(46341, 0, 46341, 0, 46341, 0, -46341, 0);
      run("hadamard", hm, hm);
      check("hadamard.const", result, mk(65536, 0, 0, 0, 0, 0, 65536, 0));

      cx = mk(0, 0, 0, 65536, 0, 65536, 0, 0);
      run("complex", cx, cx);
      check("complex.const", result, mk(-65536, 0, 0, 0, 0, 0, -65536, 0));

      sat = mk(98304, 0, 98304, 0, 98304, 0, 98304, 0);
      run("saturate", sat, sat);
      check("saturate.const", result, mk(131071, 0, 131071, 0, 131071, 0, 131071, 0));
      check("saturate.ovf", 144'(overflow), 144'(1));
      run("ident_sq", ident, ident);
      check("ident_sq.ovf_clear", 144'(overflow), 144'(0));

      run("rounding", mk(32768, 0, 0, 0, 0, 0, 0, 0), mk(-1, 0, 0, 0, 0, 0, 0, 0));
`ifdef MATRIX_MULTIPLIER_ROUND_EN
      check("rounding.const", 144'(result[0][0][0]), 144'(18'd0));
`else
      check("rounding.const", 144'(result[0][0][0]), 144'(18'h3ffff));
`endif

      for (int r = 0; r < 4; r++) begin
         run("random_full", {$urandom, $urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom, $urandom});
         for (int e = 0; e < 8; e++) tmp[e/4][(e/2)%2][e%2] = N'($urandom_range(131071) - 65536);
         run("random_small", tmp, {$urandom, $urandom, $urandom, $urandom, $urandom});
      end

      // ready held high: starts are accepted every 10 clocks
      @(negedge clk);
      mtx_a = ident; mtx_b = bm; ready = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk);
         #1;
         bz[n] = busy;
         dn[n] = done;
         ebz[n] = (n % 10) < 8;
         edn[n] = (n % 10) == 8;
      end
      ready = 1'b0;
      check("held.busy_pattern", 144'(bz), 144'(ebz));
      check("held.done_pattern", 144'(dn), 144'(edn));
      check("held.result", result, bm);

      // reset in the middle of an operation
      @(negedge clk);
      mtx_a = sat; mtx_b = sat; ready = 1'b1;
      @(posedge clk);
      #1;
      ready = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("midreset.busy", 144'(busy), 144'(0));
      check("midreset.done", 144'(done), 144'(0));
      check("midreset.overflow", 144'(overflow), 144'(0));
      check("midreset.result", result, 144'(0));
      @(negedge clk);
      reset = 1'b0;
      dcnt = 0;
      for (int n = 0; n < 12; n++) begin
         @(posedge clk);
         #1;
         if (done) dcnt++;
      end
      check("midreset.no_done", 144'(dcnt), 144'(0));
      check("midreset.result_hold", result, 144'(0));
      run("after_reset", hm, hm);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/matrix_multiplier.md
Name: matrix_multiplier

Overview:
- Fixed-point 2x2 complex matrix multiplier that computes result = mtx_a x mtx_b.
- Sits directly downstream of sequence_multiplier, which drives mtx_a, mtx_b and ready, and consumes done (as multiplier_done) and result.
- Uses four real multipliers (one complex MAC) time-shared over 8 MAC cycles; operands are latched on start and results are presented atomically.

Parameters:
- NUMERIC_BITS, 18, width of each signed real/imag component.
- FRAC_BITS, 16, fraction bits. Format is signed Q(NUMERIC_BITS-FRAC_BITS).FRAC_BITS, default range [-2, 2-2^-16].

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mtx_a  input  [NUMERIC_BITS-1:0] x [1:0][1:0][1:0]  left operand, indexed [row][col][0=real,1=imag].
- mtx_b  input  same shape  right operand.
- ready  input  1  start request; sampled only in IDLE.
- busy  output  1  high from the start edge until done is asserted.
- done  output  1  one-cycle pulse; result is valid from this cycle.
- result  output  same shape  product, held until the next done.
- overflow  output  1  high if any result component saturated in the operation just completed; updates with done.

Behaviour:
- Reset (any time, including mid-operation): state=IDLE, busy=0, done=0, overflow=0, result=all zero, operand/accumulator registers=0. The operation in flight is discarded and no done is issued.
- States: IDLE, MAC, DONE.
- IDLE, edge E0 with ready=1: latch mtx_a and mtx_b into internal registers; clear sticky overflow; busy<=1; step counter<=0; go to MAC.
- ready is ignored outside IDLE; operand inputs may change freely after E0.
- MAC, edges E1..E8, counter 0..7:
  - element (i,j) = counter[2:1], order (0,0),(0,1),(1,0),(1,1); k=counter[0].
  - Each cycle computes the complex product A[i][k]*B[k][j]:
    - re = ar*br - ai*bi
    - im = ar*bi + ai*br
    - full-precision 2*NUMERIC_BITS products, summed into (2*NUMERIC_BITS+2)-bit signed accumulators.
  - k=0 cycle: accumulator is loaded. k=1 cycle: accumulator is added to, then the element is finalised into an internal staging buffer.
- Finalise, per component:
  - Arithmetic shift right by FRAC_BITS (floor).
  - Saturate to [-2^(NUMERIC_BITS-1), 2^(NUMERIC_BITS-1)-1].
  - Any clamp sets the sticky overflow.
- At E8:
  - result<=staging buffer (all 8 components at once).
  - overflow output<=sticky flag.
  - done<=1, busy<=0, state->DONE.
- DONE: at E9, done<=0 and state->IDLE. ready=1 during the DONE cycle is not accepted; the earliest next start is sampled at E10.
- Latency: start edge to done high = 8 clocks. Throughput: one product per 10 clocks.
- result and overflow do not change between done pulses.

Optional Feature:
- Macro: MATRIX_MULTIPLIER_ROUND_EN.
- Defined: finalise adds 2^(FRAC_BITS-1) to the accumulator before the shift (round half up), then saturates.
- Undefined: pure floor truncation.
- Latency, ports and overflow semantics are identical in both builds.

Test Plan:
1. Identity x B: A=[[65536,0],[0,65536]] (real), B with components 1..8 mixed-sign, ready 1 cycle -> done exactly 8 clocks after start edge, result==B, overflow=0, busy high for 8 cycles.
2. Hadamard squared: all A and B reals ±46341 (H), imag 0 -> result diag real=65536, off-diag real=0, all imag 0, in both macro builds.
3. Complex sign check: A=B=[[0,i],[i,0]] (imag 65536) -> result real diag=-65536, all else 0.
4. Saturation: A=B all reals 98304 (1.5), imag 0 -> every real component=131071, imag=0, overflow=1; a following identity x identity run -> overflow=0.
5. Rounding: A[0][0].re=32768, B[0][0].re=-1, all else 0 -> result[0][0].re=-1 without the macro, 0 with MATRIX_MULTIPLIER_ROUND_EN.
6. Control:
   - ready held high continuously -> starts only at E0 and E10.
   - mtx_a changed at E1 -> result uses the E0 values.
   - reset pulsed at E4 -> no done, all outputs zero; a fresh start then completes normally.
